// File: rtl/rate_pkg.sv
// Rate definitions shared by the prescaler and the rate detector.
// Codes run from 000 (5 Hz) to 111 (100 Hz).
package rate_pkg;

  localparam int unsigned CLK_HZ = 32'd10_000_000;

  typedef logic [2:0] rate_code_t;

  // Rising-edge-to-rising-edge period in clk cycles, indexed by rate code.
  localparam logic [0:7][31:0] NOMINAL_PERIOD = {
    32'd2_000_000, 32'd1_000_000, 32'd500_000, 32'd400_000,
    32'd285_714,   32'd200_000,   32'd133_333, 32'd100_000
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_SCAN    = 2'd2
  } det_state_t;

endpackage

// File: rtl/rate_detector_edge_sync.sv
// Two-flop synchroniser for the asynchronous tick, plus a history flop
// so a rising edge is reported for exactly one clk cycle.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic pulse_in,
  output logic rise
);

  logic sync0;
  logic sync1;
  logic hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync0 <= pulse_in;
      sync1 <= sync0;
      hist  <= sync1;
    end
  end

  assign rise = sync1 & ~hist;

endmodule

// File: rtl/rate_detector.sv
// Measures the period of a rate-selected tick and decodes it back to the
// prescaler rate code, locking after LOCK_COUNT consistent periods.
module rate_detector
  import rate_pkg::*;
#(
  parameter int unsigned      PERIOD_W   = 32'd22,
  parameter int unsigned      LOCK_COUNT = 32'd2,
  parameter int unsigned      TOL_SHIFT  = 32'd4,
  parameter int unsigned      TIMEOUT    = 32'd2_500_000,
  // Defaults to the package table; overriding retargets the detector to another clock.
  parameter logic [0:7][31:0] NOMINAL    = NOMINAL_PERIOD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pulse_in,
  output logic [2:0]          rate_code,
  output logic                rate_valid,
  output logic                rate_change,
  output logic [PERIOD_W-1:0] period
);

  localparam int unsigned DW = PERIOD_W + 32'd1;
  localparam int unsigned CW = $clog2(LOCK_COUNT + 32'd1);
  localparam logic [PERIOD_W-1:0] CNT_MAX     = {PERIOD_W{1'b1}};
  localparam logic [PERIOD_W-1:0] CNT_TIMEOUT = PERIOD_W'(TIMEOUT);
  localparam logic [CW-1:0]       CAND_LOCK   = CW'(LOCK_COUNT);

  logic                rise;
  det_state_t          state;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] captured;
  logic [2:0]          idx;
  logic                found;
  rate_code_t          found_code;
  rate_code_t          cand;
  logic [CW-1:0]       cand_cnt;

  logic [DW-1:0] cap_ext;
  logic [DW-1:0] nom_ext;
  logic [DW-1:0] diff;
  logic [DW-1:0] tol;
  logic          hit;
  logic          res_valid;
  rate_code_t    res_code;
  rate_code_t    next_cand;
  logic [CW-1:0] next_cnt;
  logic          do_lock;

  edge_sync u_edge_sync (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .rise     (rise)
  );

  // One extra bit keeps the absolute difference from wrapping.
  always_comb begin
    cap_ext = {1'b0, captured};
    nom_ext = DW'(NOMINAL[idx]);
    if (cap_ext >= nom_ext) begin
      diff = cap_ext - nom_ext;
    end else begin
      diff = nom_ext - cap_ext;
    end
    tol = nom_ext >> TOL_SHIFT;
    hit = (diff <= tol);
  end

  // Outcome of the final scan step and the resulting candidate/lock update.
  always_comb begin
    res_valid = found | hit;
    res_code  = found ? found_code : idx;
    next_cand = cand;
    next_cnt  = cand_cnt;
    if (!res_valid) begin
      next_cnt = '0;
    end else if (res_code == cand) begin
      next_cnt = (cand_cnt >= CAND_LOCK) ? CAND_LOCK : cand_cnt + CW'(1);
    end else begin
      next_cand = res_code;
      next_cnt  = CW'(1);
    end
    do_lock = (next_cnt == CAND_LOCK) && (!rate_valid || (next_cand != rate_code));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      captured    <= '0;
      idx         <= 3'd0;
      found       <= 1'b0;
      found_code  <= 3'd0;
      cand        <= 3'd0;
      cand_cnt    <= '0;
      rate_code   <= 3'd0;
      rate_valid  <= 1'b0;
      rate_change <= 1'b0;
      period      <= '0;
    end else begin
      rate_change <= 1'b0;
      if (rise) begin
        cnt <= PERIOD_W'(1);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + PERIOD_W'(1);
      end else begin
        cnt <= cnt;
      end

      case (state)
        ST_IDLE: begin
          if (rise) begin
            state <= ST_MEASURE;
          end else if (cnt >= CNT_TIMEOUT) begin
            rate_valid <= 1'b0;
            cand_cnt   <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_MEASURE: begin
          if (rise) begin
            period   <= cnt;
            captured <= cnt;
            idx      <= 3'd0;
            found    <= 1'b0;
            state    <= ST_SCAN;
          end else if (cnt >= CNT_TIMEOUT) begin
            rate_valid <= 1'b0;
            cand_cnt   <= '0;
            state      <= ST_IDLE;
          end else begin
            state <= ST_MEASURE;
          end
        end
        ST_SCAN: begin
          // A new edge discards the classification in progress.
          if (rise) begin
            period   <= cnt;
            captured <= cnt;
            idx      <= 3'd0;
            found    <= 1'b0;
          end else if (idx == 3'd7) begin
            cand     <= next_cand;
            cand_cnt <= next_cnt;
            state    <= ST_MEASURE;
            if (do_lock) begin
              rate_code   <= next_cand;
              rate_valid  <= 1'b1;
              rate_change <= 1'b1;
            end
          end else begin
            if (hit && !found) begin
              found      <= 1'b1;
              found_code <= idx;
            end
            idx <= idx + 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rate_detector.sv
// Directed bench for rate_detector on a scaled period table (1 kHz-like
// periods) with a timestamp-based reference model checked every cycle.
module tb_rate_detector;

  localparam int PW   = 22;
  localparam int LOCK = 2;
  localparam int TMO  = 2500;
  localparam longint MAXP = (64'd1 << PW) - 64'd1;
  localparam logic [0:7][31:0] NOM_TB = {
    32'd2000, 32'd1000, 32'd500, 32'd400, 32'd286, 32'd200, 32'd133, 32'd100
  };

  logic          clk;
  logic          rst;
  logic          pulse_in;
  logic [2:0]    rate_code;
  logic          rate_valid;
  logic          rate_change;
  logic [PW-1:0] period;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int chg_seen = 0;
  int edge_q[$];

  // Reference model state, advanced once per clk cycle.
  bit     m_idle;
  int     m_last;
  bit     m_pend;
  int     m_due;
  longint m_pval;
  int     m_cand;
  int     m_cnt;
  int     m_code;
  bit     m_valid;
  bit     m_change;
  longint m_period;

  rate_detector #(
    .PERIOD_W   (PW),
    .LOCK_COUNT (LOCK),
    .TOL_SHIFT  (4),
    .TIMEOUT    (TMO),
    .NOMINAL    (NOM_TB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pulse_in    (pulse_in),
    .rate_code   (rate_code),
    .rate_valid  (rate_valid),
    .rate_change (rate_change),
    .period      (period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // First table entry within +-nominal/16 of p, or -1 when none is.
  function automatic int classify(input longint p);
    for (int i = 0; i < 8; i++) begin
      longint n = longint'(NOM_TB[i]);
      longint d = (p > n) ? p - n : n - p;
      if (d <= (n >> 4)) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_last = cyc; m_pend = 1'b0; m_due = 0; m_pval = 0;
    m_cand = 0; m_cnt = 0; m_code = 0; m_valid = 1'b0; m_change = 1'b0; m_period = 0;
  endtask

  task automatic model_lock(input longint p);
    int c;
    c = classify(p);
    if (c < 0) begin
      m_cnt = 0;
    end else begin
      if (c == m_cand) m_cnt = (m_cnt < LOCK) ? m_cnt + 1 : LOCK;
      else begin m_cand = c; m_cnt = 1; end
      if (m_cnt == LOCK && (!m_valid || m_cand != m_code)) begin
        m_code = m_cand; m_valid = 1'b1; m_change = 1'b1;
      end
    end
  endtask

  // Advance the model for the posedge just taken, then compare all outputs.
  always @(negedge clk) begin
    if (rst) begin
      model_reset();
      edge_q.delete();
    end else begin
      m_change = 1'b0;
      if (edge_q.size() > 0 && edge_q[0] == cyc) begin
        void'(edge_q.pop_front());
        if (m_idle) begin
          m_idle = 1'b0;
        end else begin
          m_period = (longint'(cyc - m_last) > MAXP) ? MAXP : longint'(cyc - m_last);
          m_pval = m_period;
          m_pend = 1'b1;
          m_due  = cyc + 8;
        end
        m_last = cyc;
      end else if (m_pend && cyc == m_due) begin
        m_pend = 1'b0;
        model_lock(m_pval);
      end else if (!m_pend && (cyc - m_last) >= TMO) begin
        m_valid = 1'b0; m_cnt = 0; m_idle = 1'b1;
      end
    end
    if (rate_change) chg_seen++;
    check("rate_code", rate_code, m_code);
    check("rate_valid", rate_valid, m_valid);
    check("rate_change", rate_change, m_change);
    check("period", period, m_period);
  end

  // One rising edge, then n clk cycles before the next one may start.
  task automatic wave(input int n);
    pulse_in = 1'b1;
    edge_q.push_back(cyc + 3);
    repeat (n / 2) @(negedge clk);
    pulse_in = 1'b0;
    repeat (n - n / 2) @(negedge clk);
  endtask

  int c0;

  initial begin
    rst = 1'b1;
    pulse_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_code", rate_code, 3'd0);
    check("reset_valid", rate_valid, 1'b0);
    check("reset_period", period, 0);
    rst = 1'b0;

    // 100 Hz: three edges lock code 111 with one strobe
    c0 = chg_seen;
    repeat (3) wave(100);
    check("lock100_code", rate_code, 3'b111);
    check("lock100_valid", rate_valid, 1'b1);
    check("lock100_period", period, 100);
    check("lock100_strobes", chg_seen - c0, 1);

    // switch to 5 Hz: code holds after one period, changes after two
    c0 = chg_seen;
    wave(2000);
    wave(2000);
    check("switch_hold_code", rate_code, 3'b111);
    wave(2000);
    check("switch_code", rate_code, 3'b000);
    check("switch_period", period, 2000);
    check("switch_strobes", chg_seen - c0, 1);

    // 25 Hz lock, one unmatched 150 period, then more 400 periods
    wave(400);
    wave(400);
    wave(150);
    check("lock25_code", rate_code, 3'b011);
    c0 = chg_seen;
    wave(400);
    check("unmatched_valid", rate_valid, 1'b1);
    check("unmatched_code", rate_code, 3'b011);
    check("unmatched_period", period, 150);
    wave(400);
    wave(400);
    check("unmatched_strobes", chg_seen - c0, 0);

    // tolerance: 107 is outside 100+-6, 106 is inside
    repeat (3) wave(107);
    check("tol107_code", rate_code, 3'b011);
    check("tol107_period", period, 107);
    repeat (3) wave(106);
    check("tol106_code", rate_code, 3'b111);
    check("tol106_period", period, 106);

    // timeout drops valid, keeps code; re-lock needs three edges
    c0 = chg_seen;
    repeat (2600) @(negedge clk);
    check("timeout_valid", rate_valid, 1'b0);
    check("timeout_code", rate_code, 3'b111);
    check("timeout_strobes", chg_seen - c0, 0);
    wave(100);
    wave(100);
    check("relock2_valid", rate_valid, 1'b0);
    wave(100);
    check("relock3_valid", rate_valid, 1'b1);
    check("relock3_strobes", chg_seen - c0, 1);

    // asynchronous reset in the middle of a scan
    pulse_in = 1'b1;
    edge_q.push_back(cyc + 3);
    repeat (2) @(negedge clk);
    pulse_in = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_code", rate_code, 3'd0);
    check("arst_valid", rate_valid, 1'b0);
    check("arst_change", rate_change, 1'b0);
    check("arst_period", period, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // an edge 5 cycles into a scan discards the scan in progress
    wave(100);
    wave(100);
    wave(5);
    wave(100);
    check("abort_valid", rate_valid, 1'b0);
    check("abort_period", period, 5);
    wave(100);
    wave(100);
    check("abort_relock_valid", rate_valid, 1'b1);
    check("abort_relock_code", rate_code, 3'b111);

    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
